// File: rtl/cgra_config_pkg.sv
// Shared state encoding, parameter defaults and width helpers for the CGRA
// configuration streamer and its column store.
package cgra_config_pkg;

  localparam int DEF_NUM_CHAINS   = 4;
  localparam int DEF_CHAIN_LEN    = 212;
  localparam int DEF_NUM_CONTEXTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Range check done at 32 bits so narrow index ports compare cleanly.
  function automatic logic idx_ok(input int unsigned idx, input int unsigned limit);
    return idx < limit;
  endfunction

endpackage

// File: rtl/cgra_config_store.sv
// Column store: one write port and one registered, enable-gated read port.
// The read register holds its value while rd_en is low, which keeps a
// prefetched column alive across fabric stalls.
module cgra_config_store
  import cgra_config_pkg::*;
#(
  parameter  int WIDTH  = DEF_NUM_CHAINS,
  parameter  int DEPTH  = DEF_NUM_CONTEXTS * DEF_CHAIN_LEN,
  localparam int ADDR_W = width_of(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cgra_config_streamer.sv
// Multi-context configuration source: the host loads columns, then a start
// streams one context into NUM_CHAINS parallel fabric scan chains.
module cgra_config_streamer
  import cgra_config_pkg::*;
#(
  parameter  int NUM_CHAINS   = DEF_NUM_CHAINS,
  parameter  int CHAIN_LEN    = DEF_CHAIN_LEN,
  parameter  int NUM_CONTEXTS = DEF_NUM_CONTEXTS,
  localparam int CTX_W        = width_of(NUM_CONTEXTS),
  localparam int POS_W        = width_of(CHAIN_LEN)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_we,
  input  logic [CTX_W-1:0]      load_ctx,
  input  logic [POS_W-1:0]      load_pos,
  input  logic [NUM_CHAINS-1:0] load_data,
  output logic                  load_err,
  input  logic                  start,
  input  logic [CTX_W-1:0]      start_ctx,
  input  logic                  abort,
  input  logic                  enable,
  output logic [NUM_CHAINS-1:0] bitstream,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH  = NUM_CONTEXTS * CHAIN_LEN;
  localparam int ADDR_W = width_of(DEPTH);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(CHAIN_LEN - 1);

  function automatic logic [ADDR_W-1:0] col_addr(input logic [CTX_W-1:0] c,
                                                 input logic [POS_W-1:0] p);
    return ADDR_W'(c) * ADDR_W'(CHAIN_LEN) + ADDR_W'(p);
  endfunction

  state_e                state_q, state_d;
  logic [CTX_W-1:0]      ctx_q, ctx_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [NUM_CHAINS-1:0] bitstream_q, bitstream_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic                  done_q, done_d;
  logic                  load_err_q, load_err_d;

  logic                  idle_like;
  logic                  wr_ok;
  logic                  start_ctx_ok;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [NUM_CHAINS-1:0] rd_data;

  assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ctx_ok = idx_ok(32'(start_ctx), NUM_CONTEXTS);
  assign wr_ok        = load_we && idle_like &&
                        idx_ok(32'(load_ctx), NUM_CONTEXTS) &&
                        idx_ok(32'(load_pos), CHAIN_LEN);

  cgra_config_store #(
    .WIDTH (NUM_CHAINS),
    .DEPTH (DEPTH)
  ) u_store (
    .clock   (clock),
    .wr_en   (wr_ok),
    .wr_addr (col_addr(load_ctx, load_pos)),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    pos_d       = pos_q;
    bitstream_d = bitstream_q;
    cfg_valid_d = 1'b0;
    done_d      = done_q;
    rd_en       = 1'b0;
    rd_addr     = col_addr(ctx_q, pos_q);
    // A bad start context is only reported when the start could have acted.
    load_err_d  = (load_we && !wr_ok) ||
                  (start && idle_like && !start_ctx_ok && !abort);

    if (abort) begin
      state_d     = ST_IDLE;
      bitstream_d = '0;
      done_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          bitstream_d = '0;
          if (state_q == ST_DONE) begin
            done_d = 1'b1;
          end
          if (start && start_ctx_ok) begin
            state_d = ST_FETCH;
            ctx_d   = start_ctx;
            pos_d   = '0;
            done_d  = 1'b0;
          end
        end
        ST_FETCH: begin
          rd_en   = 1'b1;
          state_d = ST_STREAM;
        end
        ST_STREAM: begin
          // On a stall nothing advances, so the read register keeps pos_q's column.
          if (enable) begin
            bitstream_d = rd_data;
            cfg_valid_d = 1'b1;
            if (pos_q == LAST_POS) begin
              state_d = ST_DONE;
            end else begin
              pos_d   = pos_q + POS_W'(1);
              rd_en   = 1'b1;
              rd_addr = col_addr(ctx_q, pos_q + POS_W'(1));
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ctx_q       <= '0;
      pos_q       <= '0;
      bitstream_q <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      pos_q       <= pos_d;
      bitstream_q <= bitstream_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bitstream = bitstream_q;
  assign cfg_valid = cfg_valid_q;
  assign done      = done_q;
  assign load_err  = load_err_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_STREAM);

endmodule

// File: tb/tb_cgra_config_streamer.sv
// Bench for cgra_config_streamer: a transaction-level model predicts every
// output each cycle, and literal checks pin the model on key scenarios.
module tb_cgra_config_streamer;

  localparam int NC    = 4;
  localparam int L     = 212;
  localparam int NCTX  = 2;
  localparam int CTX_W = 1;
  localparam int POS_W = 8;

  logic             clock;
  logic             reset_n;
  logic             load_we;
  logic [CTX_W-1:0] load_ctx;
  logic [POS_W-1:0] load_pos;
  logic [NC-1:0]    load_data;
  logic             load_err;
  logic             start;
  logic [CTX_W-1:0] start_ctx;
  logic             abort;
  logic             enable;
  logic [NC-1:0]    bitstream;
  logic             cfg_valid;
  logic             busy;
  logic             done;

  cgra_config_streamer #(
    .NUM_CHAINS   (NC),
    .CHAIN_LEN    (L),
    .NUM_CONTEXTS (NCTX)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_we   (load_we),
    .load_ctx  (load_ctx),
    .load_pos  (load_pos),
    .load_data (load_data),
    .load_err  (load_err),
    .start     (start),
    .start_ctx (start_ctx),
    .abort     (abort),
    .enable    (enable),
    .bitstream (bitstream),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: storage array plus a "stream in progress" record.
  logic [NC-1:0] m_mem [NCTX][L];
  int            cyc = 0;
  bit            m_active = 1'b0;
  bit            m_in_done = 1'b0;
  bit            m_was_active;
  int            m_ctx, m_idx, m_ready_at;
  int            lc, lp, sc;
  logic [NC-1:0] exp_bitstream = '0;
  logic          exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0; m_in_done = 1'b0;
      exp_bitstream = '0; exp_valid = 1'b0; exp_busy = 1'b0;
      exp_done = 1'b0; exp_err = 1'b0;
    end else begin
      cyc++;
      m_was_active = m_active;
      lc = int'(load_ctx); lp = int'(load_pos); sc = int'(start_ctx);
      exp_valid = 1'b0;
      exp_err = (load_we && (m_was_active || lc >= NCTX || lp >= L)) ||
                (start && !m_was_active && sc >= NCTX && !abort);
      if (load_we && !m_was_active && lc < NCTX && lp < L) m_mem[lc][lp] = load_data;
      if (abort) begin
        m_active = 1'b0; m_in_done = 1'b0;
        exp_bitstream = '0; exp_done = 1'b0;
      end else if (!m_was_active) begin
        exp_bitstream = '0;
        if (m_in_done) exp_done = 1'b1;
        if (start && sc < NCTX) begin
          m_active = 1'b1; m_in_done = 1'b0; exp_done = 1'b0;
          m_ctx = sc; m_idx = 0; m_ready_at = cyc + 2;
        end
      end else if (cyc >= m_ready_at && enable) begin
        exp_bitstream = m_mem[m_ctx][m_idx];
        exp_valid = 1'b1;
        m_idx++;
        if (m_idx == L) begin
          m_active = 1'b0; m_in_done = 1'b1;
        end
      end
      exp_busy = m_active;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("bitstream", 32'(bitstream), 32'(exp_bitstream));
      check("cfg_valid", 32'(cfg_valid), 32'(exp_valid));
      check("busy",      32'(busy),      32'(exp_busy));
      check("done",      32'(done),      32'(exp_done));
      check("load_err",  32'(load_err),  32'(exp_err));
    end
  end

  logic [NC-1:0] cols[$];
  int s_cyc, first_off, done_off;

  task automatic step();
    @(negedge clock);
    if (cfg_valid === 1'b1) begin
      cols.push_back(bitstream);
      if (first_off < 0) first_off = cyc - s_cyc;
    end
  endtask

  task automatic do_start(input int c);
    start = 1'b1; start_ctx = CTX_W'(c);
    @(negedge clock);
    start = 1'b0;
    s_cyc = cyc;
    $display("start ctx=%0d cycle=%0d", c, s_cyc);
  endtask

  // mode 0: enable high; 1: enable pattern 1,0,0,1; 2: random enable and stray writes
  task automatic collect(input int mode, input int stop_at, input bit clr);
    int k;
    bit fin;
    if (clr) begin
      cols.delete();
      first_off = -1;
    end
    done_off = -1; k = 0; fin = 1'b0;
    while (!fin && k < 2000) begin
      case (mode)
        0: enable = 1'b1;
        1: enable = (k % 4 == 0) || (k % 4 == 3);
        default: begin
          enable    = ($urandom_range(0, 3) != 0);
          load_we   = ($urandom_range(0, 7) == 0);
          load_ctx  = CTX_W'($urandom_range(0, NCTX - 1));
          load_pos  = POS_W'($urandom_range(0, 255));
          load_data = NC'($urandom);
        end
      endcase
      step();
      k++;
      if (stop_at >= 0 && cols.size() == stop_at) fin = 1'b1;
      else if (done === 1'b1) begin
        done_off = cyc - s_cyc;
        fin = 1'b1;
      end
    end
    load_we = 1'b0;
    check("stream_finished_in_budget", 32'(fin), 32'd1);
    $display("stream cols=%0d first_off=%0d done_off=%0d", cols.size(), first_off, done_off);
  endtask

  task automatic load_all(input int c, input logic [NC-1:0] mask);
    for (int p = 0; p < L; p++) begin
      load_we = 1'b1; load_ctx = CTX_W'(c); load_pos = POS_W'(p);
      load_data = NC'(p & 15) ^ mask;
      @(negedge clock);
    end
    load_we = 1'b0;
    $display("loaded ctx=%0d mask=%0h", c, mask);
  endtask

  task automatic check_seq(input string name, input logic [NC-1:0] mask);
    logic [NC-1:0] want;
    check({name, "_len"}, 32'(cols.size()), 32'(L));
    for (int i = 0; i < cols.size() && i < L; i++) begin
      want = NC'(i & 15) ^ mask;
      check(name, 32'(cols[i]), 32'(want));
    end
  endtask

  initial begin
    reset_n = 1'b1; load_we = 1'b0; load_ctx = '0; load_pos = '0; load_data = '0;
    start = 1'b0; start_ctx = '0; abort = 1'b0; enable = 1'b0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_bitstream", 32'(bitstream), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // 1: straight stream of ctx0 = p[3:0]
    load_all(0, 4'h0);
    do_start(0);
    collect(0, -1, 1'b1);
    check("t1_ncols", 32'(cols.size()), 32'd212);
    check("t1_col0", 32'(cols[0]), 32'd0);
    check("t1_col17", 32'(cols[17]), 32'd1);
    check("t1_col211", 32'(cols[211]), 32'd3);
    check("t1_first_off", 32'(first_off), 32'd2);
    check("t1_done_off", 32'(done_off), 32'd214);
    check_seq("t1_seq", 4'h0);

    // 2: enable pattern 1,0,0,1 must not skip or repeat columns
    do_start(0);
    collect(1, -1, 1'b1);
    check_seq("t2_seq", 4'h0);

    // 3: ctx1 = ~ctx0, stream ctx1 then ctx0
    load_all(1, 4'hF);
    do_start(1);
    collect(0, -1, 1'b1);
    check_seq("t3_seq_ctx1", 4'hF);
    do_start(0);
    check("t3_done_cleared", 32'(done), 32'd0);
    collect(1, -1, 1'b1);
    check_seq("t3_seq_ctx0", 4'h0);

    // 4: rejected writes (busy, then out-of-range pos)
    do_start(0);
    collect(0, 30, 1'b1);
    load_we = 1'b1; load_ctx = 1'b0; load_pos = 8'd5; load_data = 4'hF;
    step();
    load_we = 1'b0;
    check("t4_err_busy", 32'(load_err), 32'd1);
    collect(0, -1, 1'b0);
    check_seq("t4_seq_a", 4'h0);
    load_we = 1'b1; load_ctx = 1'b0; load_pos = 8'd212; load_data = 4'hA;
    @(negedge clock);
    load_we = 1'b0;
    check("t4_err_pos", 32'(load_err), 32'd1);
    @(negedge clock);
    check("t4_err_clears", 32'(load_err), 32'd0);
    do_start(0);
    collect(0, -1, 1'b1);
    check_seq("t4_seq_b", 4'h0);

    // 5: abort at column 100, then restart
    do_start(0);
    collect(0, 100, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_bitstream", 32'(bitstream), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_ncols", 32'(cols.size()), 32'd100);
    do_start(0);
    collect(0, -1, 1'b1);
    check_seq("t5_seq", 4'h0);

    // 6: asynchronous reset at column 50; storage survives
    do_start(0);
    collect(0, 50, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_cfg_valid", 32'(cfg_valid), 32'd0);
    check("t6_bitstream", 32'(bitstream), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    do_start(0);
    collect(0, -1, 1'b1);
    check_seq("t6_seq", 4'h0);

    // Randomized: idle rewrites, random contexts, random stalls and stray writes
    for (int t = 0; t < 12; t++) begin
      for (int w = 0; w < int'($urandom_range(0, 10)); w++) begin
        load_we = 1'b1;
        load_ctx = CTX_W'($urandom_range(0, NCTX - 1));
        load_pos = POS_W'($urandom_range(0, 255));
        load_data = NC'($urandom);
        @(negedge clock);
      end
      load_we = 1'b0;
      do_start(int'($urandom_range(0, NCTX - 1)));
      collect(2, -1, 1'b1);
      check("rand_ncols", 32'(cols.size()), 32'(L));
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
